mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access.sv | 167 ++++++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - EX/MEM inputs, stall, and MEM/WB outputs of the memory-access pipeline stage.
interface mem_access_if;
    logic         valid_M;
    logic         regw_M;
    logic         memw_M;
    logic         regmem_M;
    logic         vec_M;
    logic [3:0]   regScr_M;
    logic [31:0]  ALUrslt_M;
    logic [31:0]  address_M;
    logic [127:0] regrsltV_M;
    logic         stall;
    logic         valid_W;
    logic         regw_W;
    logic         regmem_W;
    logic         vec_W;
    logic [3:0]   regScr_W;
    logic [31:0]  ALUrslt_W;
    logic [31:0]  rdata_W;
    logic [127:0] rdataV_W;

    modport master (
        output valid_M, regw_M, memw_M, regmem_M, vec_M, regScr_M, ALUrslt_M, address_M, regrsltV_M,
        input  stall, valid_W, regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, rdata_W, rdataV_W
    );

    modport slave (
        input  valid_M, regw_M, memw_M, regmem_M, vec_M, regScr_M, ALUrslt_M, address_M, regrsltV_M,
        output stall, valid_W, regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, rdata_W, rdataV_W
    );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: scalar/vector data-RAM access feeding the MEM/WB register.
// Define VEC_ACCESS_EN to enable 128-bit vector loads/stores issued as 4 consecutive word beats.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

`ifdef VEC_ACCESS_EN
    typedef enum logic [1:0] {IDLE, LD_WAIT, VST, VLD} state_t;
`else
    typedef enum logic [0:0] {IDLE, LD_WAIT} state_t;
`endif

    state_t      r_state;
    logic [1:0]  r_beat;
    logic        r_valid_W;
    logic        r_regw_W;
    logic        r_regmem_W;
    logic [3:0]  r_regScr_W;
    logic [31:0] r_ALUrslt_W;
    logic [31:0] r_rdata_W;

    logic        w_vec;
    logic        w_store;
    logic        w_load;
    logic        w_wren;
    logic        w_stall;
    logic        w_done;

`ifdef VEC_ACCESS_EN
    logic         r_vec_W;
    logic [127:0] r_rdataV_W;
    logic [1:0]   w_cap_idx;

    assign w_vec     = bus.vec_M;
    // Read data trails the address by one cycle, so the beat being captured is one behind.
    assign w_cap_idx = r_beat - 2'd1;
    assign bus.vec_W    = r_vec_W;
    assign bus.rdataV_W = r_rdataV_W;
`else
    assign w_vec        = 1'b0 & bus.vec_M;
    assign bus.vec_W    = 1'b0;
    assign bus.rdataV_W = '0;
`endif

    assign w_store = bus.memw_M;
    assign w_load  = bus.regmem_M & ~bus.memw_M;

    assign mem_address = bus.address_M + {30'd0, r_beat};
    assign mem_data    = w_vec ? bus.regrsltV_M[{r_beat, 5'd0} +: 32] : bus.ALUrslt_M;

    // Reset must kill a write or stall combinationally, even with a store presented in IDLE.
    assign mem_wren  = rst & w_wren;
    assign bus.stall = rst & w_stall;

    assign bus.valid_W   = r_valid_W;
    assign bus.regw_W    = r_regw_W;
    assign bus.regmem_W  = r_regmem_W;
    assign bus.regScr_W  = r_regScr_W;
    assign bus.ALUrslt_W = r_ALUrslt_W;
    assign bus.rdata_W   = r_rdata_W;

    always_comb begin
        w_wren  = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                w_wren  = bus.valid_M & w_store;
                w_stall = bus.valid_M & (w_load | (w_vec & w_store));
            end
            LD_WAIT: begin
                w_wren  = 1'b0;
                w_stall = 1'b0;
            end
`ifdef VEC_ACCESS_EN
            VST: begin
                w_wren  = 1'b1;
                w_stall = (r_beat != 2'd3);
            end
            VLD: begin
                w_wren  = 1'b0;
                w_stall = (r_beat != 2'd0);
            end
`endif
            default: begin
                w_wren  = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    // An op completes on the edge where stall is low and there is a live op or an op in flight.
    assign w_done = ((r_state != IDLE) | bus.valid_M) & ~w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_beat      <= 2'd0;
            r_valid_W   <= 1'b0;
            r_regw_W    <= 1'b0;
            r_regmem_W  <= 1'b0;
            r_regScr_W  <= 4'd0;
            r_ALUrslt_W <= 32'd0;
            r_rdata_W   <= 32'd0;
`ifdef VEC_ACCESS_EN
            r_vec_W     <= 1'b0;
            r_rdataV_W  <= 128'd0;
`endif
        end else begin
            r_valid_W <= w_done;
            if (w_done) begin
                r_regw_W    <= bus.regw_M & ~bus.memw_M;
                r_regmem_W  <= w_load;
                r_regScr_W  <= bus.regScr_M;
                r_ALUrslt_W <= bus.ALUrslt_M;
`ifdef VEC_ACCESS_EN
                r_vec_W     <= w_vec;
`endif
            end
            case (r_state)
                IDLE: begin
                    if (bus.valid_M && w_stall) begin
`ifdef VEC_ACCESS_EN
                        if (w_vec) begin
                            r_beat  <= 2'd1;
                            r_state <= w_store ? VST : VLD;
                        end else begin
                            r_state <= LD_WAIT;
                        end
`else
                        r_state <= LD_WAIT;
`endif
                    end
                end
                LD_WAIT: begin
                    r_rdata_W <= mem_q;
                    r_state   <= IDLE;
                end
`ifdef VEC_ACCESS_EN
                VST: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state <= IDLE;
                    end
                end
                VLD: begin
                    r_rdataV_W[{w_cap_idx, 5'd0} +: 32] <= mem_q;
                    if (r_beat == 2'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - Scoreboard bench for mem_access: RAM writes and MEM/WB completions checked against queued expectations.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    logic [31:0] ram [logic [31:0]];

    always @(posedge clk) begin
        mem_q <= ram.exists(mem_address) ? ram[mem_address] : 32'h0;
        if (mem_wren === 1'b1) ram[mem_address] = mem_data;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic         regw;
        logic         regmem;
        logic         vec;
        logic [3:0]   scr;
        logic [31:0]  alu;
        logic [31:0]  rdata;
        logic [127:0] rdataV;
    } wb_t;

    wr_t exp_wr[$];
    wb_t exp_wb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    logic [31:0]  exp_rdata  = 32'h0;
    logic [127:0] exp_rdataV = 128'h0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wb_t mk(input logic regw, regmem, vec, input logic [3:0] scr, input logic [31:0] alu);
        wb_t w;
        w.regw   = regw;
        w.regmem = regmem;
        w.vec    = vec;
        w.scr    = scr;
        w.alu    = alu;
        w.rdata  = exp_rdata;
        w.rdataV = exp_rdataV;
        return w;
    endfunction

    function automatic wb_t obs_wb();
        wb_t w;
        w.regw   = bus.regw_W;
        w.regmem = bus.regmem_W;
        w.vec    = bus.vec_W;
        w.scr    = bus.regScr_W;
        w.alu    = bus.ALUrslt_W;
        w.rdata  = bus.rdata_W;
        w.rdataV = bus.rdataV_W;
        return w;
    endfunction

    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            n_cmp++;
            assert (exp_wr.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write observed=%h/%h expected=none", mem_address, mem_data);
            end
            if (exp_wr.size() != 0) begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("ram_write", {mem_address, mem_data}, e);
            end
        end
        if (bus.valid_W === 1'b1) begin
            n_cmp++;
            assert (exp_wb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_valid_W observed=1 expected=0");
            end
            if (exp_wb.size() != 0) begin
                wb_t e;
                e = exp_wb.pop_front();
                chk("wb_fields", obs_wb(), e);
            end
        end
    end

    task automatic issue(input logic regw, memw, regmem, vec, input logic [3:0] scr,
                         input logic [31:0] alu, addr, input logic [127:0] v, output int stalls);
        bus.valid_M    = 1'b1;
        bus.regw_M     = regw;
        bus.memw_M     = memw;
        bus.regmem_M   = regmem;
        bus.vec_M      = vec;
        bus.regScr_M   = scr;
        bus.ALUrslt_M  = alu;
        bus.address_M  = addr;
        bus.regrsltV_M = v;
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.stall !== 1'b1) break;
            stalls++;
        end
        @(posedge clk);
        #1;
        bus.valid_M = 1'b0;
        chk("valid_W_at_done", bus.valid_W, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int st;
        logic [127:0] v1;
        logic [127:0] v2;
        v1 = 128'h44444444_33333333_22222222_11111111;
        v2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        bus.valid_M = 1'b0; bus.regw_M = 1'b0; bus.memw_M = 1'b0; bus.regmem_M = 1'b0;
        bus.vec_M = 1'b0; bus.regScr_M = 4'd0; bus.ALUrslt_M = 32'd0; bus.address_M = 32'd0;
        bus.regrsltV_M = 128'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", bus.stall, 1'b0);
        chk("reset_wren", mem_wren, 1'b0);
        chk("reset_valid_W", bus.valid_W, 1'b0);
        chk("reset_wb_fields", obs_wb(), 199'd0);

        // ALU op presented during reset is accepted on the first edge after release
        bus.valid_M = 1'b1; bus.regw_M = 1'b1; bus.regScr_M = 4'd3; bus.ALUrslt_M = 32'h0000FFFF;
        exp_wb.push_back(mk(1'b1, 1'b0, 1'b0, 4'd3, 32'h0000FFFF));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_M = 1'b0;
        chk("alu_valid_W", bus.valid_W, 1'b1);
        chk("alu_result_W", bus.ALUrslt_W, 32'h0000FFFF);
        @(posedge clk);
        #1;
        chk("valid_W_single_pulse", bus.valid_W, 1'b0);

        exp_wr.push_back('{32'h00010004, 32'h12345678});
        exp_wb.push_back(mk(1'b0, 1'b0, 1'b0, 4'd5, 32'h12345678));
        issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h12345678, 32'h00010004, 128'd0, st);
        chk("store_stalls", st, 0);

        exp_rdata = 32'h12345678;
        exp_wb.push_back(mk(1'b1, 1'b1, 1'b0, 4'd7, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'h0, 32'h00010004, 128'd0, st);
        chk("load_stalls", st, 1);
        chk("load_rdata_W", bus.rdata_W, 32'h12345678);

        // memw and regmem both set: the op is a store
        exp_wr.push_back('{32'h00000020, 32'hCAFEF00D});
        exp_wb.push_back(mk(1'b0, 1'b0, 1'b0, 4'd2, 32'hCAFEF00D));
        issue(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 32'hCAFEF00D, 32'h00000020, 128'd0, st);
        chk("priority_store_stalls", st, 0);

        exp_rdata = 32'hCAFEF00D;
        exp_wb.push_back(mk(1'b1, 1'b1, 1'b0, 4'd9, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 32'h0, 32'h00000020, 128'd0, st);
        chk("priority_load_stalls", st, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("bubble_valid_W", bus.valid_W, 1'b0);

`ifdef VEC_ACCESS_EN
        for (int i = 0; i < 4; i++) exp_wr.push_back('{32'h10 + i, v1[32*i +: 32]});
        exp_wb.push_back(mk(1'b0, 1'b0, 1'b1, 4'd4, 32'h0));
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'h10, v1, st);
        chk("vst_stalls", st, 3);

        exp_rdataV = v1;
        exp_wb.push_back(mk(1'b1, 1'b1, 1'b1, 4'd6, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h0, 32'h10, 128'd0, st);
        chk("vld_stalls", st, 4);
        chk("vld_rdataV_W", bus.rdataV_W, v1);

        exp_wr.push_back('{32'hFFFFFFFE, v2[31:0]});
        exp_wr.push_back('{32'hFFFFFFFF, v2[63:32]});
        exp_wr.push_back('{32'h00000000, v2[95:64]});
        exp_wr.push_back('{32'h00000001, v2[127:96]});
        exp_wb.push_back(mk(1'b0, 1'b0, 1'b1, 4'd1, 32'h0));
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0, 32'hFFFFFFFE, v2, st);
        chk("vst_wrap_stalls", st, 3);

        exp_rdataV = v2;
        exp_wb.push_back(mk(1'b1, 1'b1, 1'b1, 4'd8, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 32'h0, 32'hFFFFFFFE, 128'd0, st);
        chk("vld_wrap_rdataV_W", bus.rdataV_W, v2);

        // reset lands during beat 2 of a vector store; beat 3 must never appear
        for (int i = 0; i < 3; i++) exp_wr.push_back('{32'h40 + i, v1[32*i +: 32]});
        bus.valid_M = 1'b1; bus.regw_M = 1'b0; bus.memw_M = 1'b1; bus.regmem_M = 1'b0;
        bus.vec_M = 1'b1; bus.regScr_M = 4'd2; bus.ALUrslt_M = 32'h0; bus.address_M = 32'h40;
        bus.regrsltV_M = v1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_wren", mem_wren, 1'b0);
        chk("abort_stall", bus.stall, 1'b0);
        chk("abort_valid_W", bus.valid_W, 1'b0);
        chk("abort_wb_fields", obs_wb(), 199'd0);
`else
        // vec_M is ignored: single-beat store and load
        exp_wr.push_back('{32'h00000030, 32'h55AA55AA});
        exp_wb.push_back(mk(1'b0, 1'b0, 1'b0, 4'd4, 32'h55AA55AA));
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h55AA55AA, 32'h00000030, v1, st);
        chk("novec_store_stalls", st, 0);

        exp_rdata = 32'h55AA55AA;
        exp_wb.push_back(mk(1'b1, 1'b1, 1'b0, 4'd6, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h0, 32'h00000030, 128'd0, st);
        chk("novec_load_stalls", st, 1);
        chk("novec_rdataV_W", bus.rdataV_W, 128'd0);

        // reset lands in LD_WAIT; then a store presented during reset must not write
        bus.valid_M = 1'b1; bus.regw_M = 1'b1; bus.memw_M = 1'b0; bus.regmem_M = 1'b1;
        bus.vec_M = 1'b0; bus.regScr_M = 4'd2; bus.address_M = 32'h00000030;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_stall", bus.stall, 1'b0);
        chk("abort_valid_W", bus.valid_W, 1'b0);
        chk("abort_wb_fields", obs_wb(), 199'd0);
        bus.memw_M = 1'b1;
        #1;
        chk("abort_wren", mem_wren, 1'b0);
`endif
        bus.valid_M = 1'b0;
        exp_rdata  = 32'h0;
        exp_rdataV = 128'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        exp_wb.push_back(mk(1'b1, 1'b0, 1'b0, 4'd11, 32'hA5A5A5A5));
        issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 32'hA5A5A5A5, 32'h0, 128'd0, st);
        chk("post_reset_alu_stalls", st, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_completions", exp_wb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
